// File: rtl/cartram_dump.sv
// cartram_dump: answers HPS ioctl upload reads with bytes fetched from cart RAM,
// tracks whether cart RAM changed since the last complete dump, and raises an
// upload request when a save is asked for while the RAM is dirty.
module cartram_dump #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned RD_LATENCY   = 1,
  parameter logic [7:0]  UPLOAD_INDEX = 8'h01
) (
  input  logic              CLK_SYS,
  input  logic              RESB,
  input  logic              IOCTL_UPLOAD,
  input  logic [7:0]        IOCTL_INDEX,
  input  logic              IOCTL_RD,
  input  logic [24:0]       IOCTL_ADDR,
  output logic [7:0]        IOCTL_DIN,
  output logic              IOCTL_WAIT,
  output logic              IOCTL_UPLOAD_REQ,
  input  logic              SAVE_REQ,
  input  logic              CART_RAM_WR,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_RD,
  input  logic [7:0]        RAM_DATA,
  output logic              DUMP_ACTIVE,
  output logic              RAM_DIRTY
);

  typedef enum logic [1:0] {IDLE, FETCH, WAITD} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  state_t            state_q;
  logic [1:0]        lat_q;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              upreq_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_rd_q;
  logic              active_q;
  logic              dirty_q;

  logic              sel;
  logic              in_range;
  logic              last_byte;
  logic              dirty_d;

  // Decode upload target and address range; compute dirty flag next state
  always_comb begin
    sel       = IOCTL_UPLOAD && (IOCTL_INDEX == UPLOAD_INDEX);
    in_range  = (IOCTL_ADDR >> ADDR_W) == '0;
    // Completion of the top byte only counts when the fetch is not being aborted
    last_byte = (state_q == WAITD) && sel && (lat_q == '0) && (ram_addr_q == '1);
    dirty_d   = dirty_q;
    if (last_byte) dirty_d = 1'b0;
    // A CPU write in the same cycle as the final byte keeps the RAM dirty
    if (CART_RAM_WR) dirty_d = 1'b1;
  end

  // Fetch FSM with registered outputs, dirty tracking and save-request pulse
  always_ff @(posedge CLK_SYS or negedge RESB) begin
    if (!RESB) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      din_q      <= '0;
      wait_q     <= 1'b0;
      upreq_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      active_q   <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      active_q <= sel;
      dirty_q  <= dirty_d;
      upreq_q  <= SAVE_REQ && dirty_q && !sel;
      ram_rd_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (IOCTL_RD && sel) begin
            if (in_range) begin
              ram_addr_q <= IOCTL_ADDR[ADDR_W-1:0];
              wait_q     <= 1'b1;
              state_q    <= FETCH;
            end else begin
              din_q <= 8'hFF;
            end
          end
        end
        FETCH: begin
          if (!sel) begin
            wait_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ram_rd_q <= 1'b1;
            lat_q    <= LAT_INIT;
            state_q  <= WAITD;
          end
        end
        WAITD: begin
          if (!sel) begin
            wait_q  <= 1'b0;
            state_q <= IDLE;
          end else if (lat_q != '0) begin
            lat_q <= lat_q - 2'd1;
          end else begin
            din_q   <= RAM_DATA;
            wait_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IOCTL_DIN        = din_q;
  assign IOCTL_WAIT       = wait_q;
  assign IOCTL_UPLOAD_REQ = upreq_q;
  assign RAM_ADDR         = ram_addr_q;
  assign RAM_RD           = ram_rd_q;
  assign DUMP_ACTIVE      = active_q;
  assign RAM_DIRTY        = dirty_q;

endmodule

// File: doc/cartram_dump.md
# cartram_dump

Streams the cartridge's battery-backed work RAM back to the HPS over the ioctl upload channel. It is the read-side counterpart of the ROM download path: the download path writes bytes from `ioctl_dout` into core memories, while this block answers HPS upload read strobes with bytes fetched from cart RAM. It also tracks whether that RAM is dirty and raises an upload request when a save is asked for. It sits in `emu` between `hps_io` and the spare read port of the cart RAM inside `scv`.

## Interface
Parameters:
- `ADDR_W`, default 13: cart RAM address width; the RAM holds 2**ADDR_W bytes (8 KiB).
- `RD_LATENCY`, default 1: cycles from `RAM_RD` to valid `RAM_DATA`, range 1..3.
- `UPLOAD_INDEX`, default 8'h01: ioctl index this block answers to.

Ports:
- `CLK_SYS` in 1: system clock; the only clock.
- `RESB` in 1: reset, asynchronous and active-low.
- `IOCTL_UPLOAD` in 1: HPS upload in progress.
- `IOCTL_INDEX` in 8: upload target index.
- `IOCTL_RD` in 1: single-cycle byte read strobe.
- `IOCTL_ADDR` in 25: byte address of the current read.
- `IOCTL_DIN` out 8: byte returned to the HPS.
- `IOCTL_WAIT` out 1: high while a fetch is outstanding.
- `IOCTL_UPLOAD_REQ` out 1: single-cycle pulse asking the HPS to start an upload.
- `SAVE_REQ` in 1: single-cycle save request from the OSD/status logic.
- `CART_RAM_WR` in 1: the CPU wrote cart RAM this cycle.
- `RAM_ADDR` out ADDR_W: read address to the cart RAM.
- `RAM_RD` out 1: single-cycle read strobe to the cart RAM.
- `RAM_DATA` in 8: cart RAM read data.
- `DUMP_ACTIVE` out 1: high while `IOCTL_UPLOAD` is high and `IOCTL_INDEX` equals `UPLOAD_INDEX`.
- `RAM_DIRTY` out 1: cart RAM has changed since the last complete dump.

## Operation
- `sel` = `IOCTL_UPLOAD` && (`IOCTL_INDEX` == `UPLOAD_INDEX`). `DUMP_ACTIVE` is `sel` registered.
- FSM states: IDLE, FETCH, WAITD, with a latency counter `lat` of 2 bits.
- **IDLE**
  - `IOCTL_RD` && `sel` && `IOCTL_ADDR` < 2**ADDR_W: latch `RAM_ADDR` = `IOCTL_ADDR[ADDR_W-1:0]`, set `IOCTL_WAIT`=1, go to FETCH.
  - `IOCTL_RD` && `sel` && address out of range: load `IOCTL_DIN`=8'hFF, issue no `RAM_RD`, leave `IOCTL_WAIT` low, stay in IDLE.
  - `IOCTL_RD` without `sel`: ignored.
- **FETCH**: assert `RAM_RD` for exactly one cycle, set `lat`=RD_LATENCY-1, go to WAITD.
- **WAITD**
  - `lat`≠0: decrement `lat`.
  - `lat`==0: load `IOCTL_DIN`=`RAM_DATA`, clear `IOCTL_WAIT`, go to IDLE. If the loaded address was 2**ADDR_W-1, this is the "last byte" event.
- `IOCTL_RD` in FETCH or WAITD is ignored; no queueing.
- If `sel` drops in FETCH or WAITD, abort to IDLE at the next edge: `IOCTL_WAIT` clears, no further `RAM_RD`, `IOCTL_DIN` is unchanged, and no last-byte event occurs.
- **Dirty flag**
  - `CART_RAM_WR` sets `RAM_DIRTY`.
  - The last-byte event clears `RAM_DIRTY`.
  - When both happen in the same cycle, the set wins.
- **Save request**: `SAVE_REQ` && `RAM_DIRTY` && !`sel` produces a one-cycle pulse on `IOCTL_UPLOAD_REQ` at the next edge. `SAVE_REQ` while clean or during an active dump is dropped.
- Reset values: `IOCTL_DIN`=0, `IOCTL_WAIT`=0, `IOCTL_UPLOAD_REQ`=0, `RAM_ADDR`=0, `RAM_RD`=0, `DUMP_ACTIVE`=0, `RAM_DIRTY`=0, FSM in IDLE. Reset asserted mid-fetch forces these values immediately.

## Timing
- The edge that samples `IOCTL_RD` is E0.
- `IOCTL_WAIT` and `RAM_ADDR` are valid after E0.
- `RAM_RD` is high between E1 and E2.
- `RAM_DATA` is sampled at E(1+RD_LATENCY).
- `IOCTL_DIN` is valid and `IOCTL_WAIT` low after E(1+RD_LATENCY). With RD_LATENCY=1, that is after E2.
- Back-to-back reads: the next `IOCTL_RD` is accepted at the same edge `IOCTL_WAIT` falls only if the FSM is in IDLE at that edge. Otherwise accept it the following cycle; the minimum spacing is RD_LATENCY+2 cycles.
- Out-of-range reads: `IOCTL_DIN`=FF is valid after E0.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Single read, RD_LATENCY=1:** preload RAM[0x0123]=8'h5A; sel=1; pulse `IOCTL_RD` with `IOCTL_ADDR`=0x123 -> `IOCTL_WAIT` high for 2 cycles, `RAM_RD` exactly one pulse with `RAM_ADDR`=0x123, `IOCTL_DIN`=8'h5A when WAIT falls.
- **Full sweep:** RAM[i]=i^8'hA5, `CART_RAM_WR` pulsed first so dirty=1; read 0..0x1FFF back to back -> every byte matches, `RAM_DIRTY` clears after the 0x1FFF byte. Repeat with RD_LATENCY=3 and check WAIT lasts 4 cycles per read.
- **Out-of-range:** read address 0x2000 -> `IOCTL_DIN`=8'hFF one edge later, no `RAM_RD`, WAIT stays 0. Same read with `IOCTL_INDEX`=8'h00 -> no response at all.
- **Abort:** drop `IOCTL_UPLOAD` the cycle after `RAM_RD` -> WAIT low next edge, `IOCTL_DIN` unchanged, FSM accepts a new read once sel returns.
- **Dirty race:** `CART_RAM_WR` in the same cycle as the last-byte event -> `RAM_DIRTY` stays 1. `SAVE_REQ` then produces one `IOCTL_UPLOAD_REQ` pulse. `SAVE_REQ` while clean, or while sel=1 -> no pulse.
- **Async reset mid-fetch:** assert `RESB`=0 in WAITD -> all outputs go to reset values without a clock edge, dirty=0.
